// File: rtl/neq_vector_checker.sv
// neq_vector_checker: consumes (a, b, expected a!=b) vectors and gives a pass/fail verdict; NEQ_CHECK_CAPTURE_EN enables first-mismatch operand capture
module neq_vector_checker #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vec,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_exp_neq,
  output logic               busy,
  output logic               done,
  output logic               passed,
  output logic [COUNT_W-1:0] err_count,
  output logic [COUNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0]   cap_a,
  output logic [WIDTH-1:0]   cap_b
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [COUNT_W-1:0] num_q, num_d, idx_q, idx_d, err_q, err_d, first_q, first_d;
  logic passed_q, passed_d;
  logic go, acc, mis, first_mis;
  always_comb begin
    go        = start && state_q != RUN;
    acc       = in_valid && state_q == RUN;
    mis       = acc && ((in_a != in_b) != in_exp_neq);
    first_mis = mis && err_q == '0;
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    err_d     = err_q;
    first_d   = first_q;
    passed_d  = passed_q;
    if (go) begin
      state_d  = num_vec == '0 ? DONE : RUN;
      num_d    = num_vec;
      idx_d    = '0;
      err_d    = '0;
      first_d  = '1;
      passed_d = num_vec == '0;
    end else if (acc) begin
      err_d   = mis && err_q != '1 ? err_q + 1'b1 : err_q;
      first_d = first_mis ? idx_q : first_q;
      idx_d   = idx_q + 1'b1;
      if (idx_q == num_q - 1'b1) begin
        state_d  = DONE;
        passed_d = err_d == '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      num_q    <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      first_q  <= '1;
      passed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      first_q  <= first_d;
      passed_q <= passed_d;
    end
  end
  assign in_ready      = state_q == RUN;
  assign busy          = state_q == RUN;
  assign done          = state_q == DONE;
  assign passed        = passed_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
`ifdef NEQ_CHECK_CAPTURE_EN
  logic [WIDTH-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  always_comb begin
    cap_a_d = go ? '0 : first_mis ? in_a : cap_a_q;
    cap_b_d = go ? '0 : first_mis ? in_b : cap_b_q;
  end
  always_ff @(posedge clk) begin
    cap_a_q <= reset ? '0 : cap_a_d;
    cap_b_q <= reset ? '0 : cap_b_d;
  end
  assign cap_a = cap_a_q;
  assign cap_b = cap_b_q;
`else
  assign cap_a = '0;
  assign cap_b = '0;
`endif
endmodule

// File: tb/tb_neq_vector_checker.sv
// tb_neq_vector_checker: directed vectors against an abstract run model for a 16-bit and a 2-bit counter instance
module tb_neq_vector_checker;
  logic clk = 1'b0, reset = 1'b1, start0 = 1'b0, start2 = 1'b0, in_valid = 1'b0, in_exp_neq = 1'b0;
  logic [15:0] num_vec = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic rdy0, busy0, done0, pass0, rdy2, busy2, done2, pass2;
  logic [15:0] err0, first0;
  logic [1:0] err2, first2;
  logic [31:0] ca0, cb0, ca2, cb2;
  int total = 0, bad = 0;
  logic armed = 1'b0;
  int started[2], tgt[2], nacc[2], nerr[2], fidx[2];
  logic [31:0] ma[2], mb[2];
  always #5 clk = ~clk;
  neq_vector_checker #(.WIDTH(32), .COUNT_W(16)) d16 (
    .clk(clk), .reset(reset), .start(start0), .num_vec(num_vec), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_exp_neq(in_exp_neq), .busy(busy0), .done(done0), .passed(pass0),
    .err_count(err0), .first_err_idx(first0), .cap_a(ca0), .cap_b(cb0));
  neq_vector_checker #(.WIDTH(32), .COUNT_W(2)) d2 (
    .clk(clk), .reset(reset), .start(start2), .num_vec(num_vec[1:0]), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_exp_neq(in_exp_neq), .busy(busy2), .done(done2), .passed(pass2),
    .err_count(err2), .first_err_idx(first2), .cap_a(ca2), .cap_b(cb2));
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic bit running(int k);
    return started[k] != 0 && nacc[k] < tgt[k];
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic st;
      st = k == 0 ? start0 : start2;
      if (reset) begin
        started[k] = 0; tgt[k] = 0; nacc[k] = 0; nerr[k] = 0; fidx[k] = -1; ma[k] = 0; mb[k] = 0;
      end else if (st && !running(k)) begin
        started[k] = 1; tgt[k] = k == 0 ? int'(num_vec) : int'(num_vec[1:0]);
        nacc[k] = 0; nerr[k] = 0; fidx[k] = -1; ma[k] = 0; mb[k] = 0;
      end else if (running(k) && in_valid) begin
        if ((in_a != in_b) != in_exp_neq) begin
          if (nerr[k] == 0) begin
            fidx[k] = nacc[k]; ma[k] = in_a; mb[k] = in_b;
          end
          nerr[k]++;
        end
        nacc[k]++;
      end
    end
  end
  task automatic cmp(int k);
    int mx;
    bit dn;
    mx = k == 0 ? 65535 : 3;
    dn = started[k] != 0 && !running(k);
    chk(k == 0 ? "ready16" : "ready2", k == 0 ? rdy0 : rdy2, running(k));
    chk(k == 0 ? "busy16" : "busy2", k == 0 ? busy0 : busy2, running(k));
    chk(k == 0 ? "done16" : "done2", k == 0 ? done0 : done2, dn);
    chk(k == 0 ? "err16" : "err2", k == 0 ? err0 : err2, nerr[k] > mx ? mx : nerr[k]);
    chk(k == 0 ? "first16" : "first2", k == 0 ? first0 : first2, fidx[k] < 0 ? mx : fidx[k]);
    if (dn || started[k] == 0)
      chk(k == 0 ? "passed16" : "passed2", k == 0 ? pass0 : pass2, dn && nerr[k] == 0);
`ifdef NEQ_CHECK_CAPTURE_EN
    chk(k == 0 ? "capa16" : "capa2", k == 0 ? ca0 : ca2, ma[k]);
    chk(k == 0 ? "capb16" : "capb2", k == 0 ? cb0 : cb2, mb[k]);
`else
    chk(k == 0 ? "capa16" : "capa2", k == 0 ? ca0 : ca2, 0);
    chk(k == 0 ? "capb16" : "capb2", k == 0 ? cb0 : cb2, 0);
`endif
  endtask
  always @(negedge clk) if (armed) begin
    cmp(0);
    cmp(1);
  end
  task automatic pulse(int k, int n);
    num_vec = 16'(n);
    if (k == 0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
  endtask
  task automatic send(int k, int a, int b, bit e);
    bit ok = 0;
    in_a = a; in_b = b; in_exp_neq = e; in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((k == 0 ? rdy0 : rdy2) === 1'b1) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_err", err0, 0);
    chk("rst_first", first0, 16'hFFFF); chk("rst_ready", rdy0, 0); chk("rst_passed", pass0, 0);
    @(posedge clk); #1;
    pulse(0, 5);
    send(0, 0, 0, 0); send(0, 1, 0, 1); send(0, 1, 1, 0); send(0, 1002, 1001, 1); send(0, 1001, 1001, 0);
    @(negedge clk);
    chk("t1_done", done0, 1); chk("t1_passed", pass0, 1); chk("t1_err", err0, 0); chk("t1_first", first0, 16'hFFFF);
    @(posedge clk); #1;
    pulse(0, 5);
    send(0, 0, 0, 0); send(0, 1, 0, 1); send(0, 1, 1, 1); send(0, 1002, 1001, 1); send(0, 1001, 1001, 1);
    @(negedge clk);
    chk("t2_done", done0, 1); chk("t2_passed", pass0, 0); chk("t2_err", err0, 2); chk("t2_first", first0, 2);
`ifdef NEQ_CHECK_CAPTURE_EN
    chk("t2_capa", ca0, 1); chk("t2_capb", cb0, 1);
`endif
    @(posedge clk); #1;
    pulse(0, 3);
    send(0, 4, 4, 0); send(0, 4, 5, 1);
    repeat (2) @(posedge clk);
    #1 pulse(0, 7);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_busy", busy0, 1); chk("t3_done", done0, 0);
    @(posedge clk); #1;
    send(0, 9, 3, 1);
    @(negedge clk);
    chk("t3_done_end", done0, 1); chk("t3_passed", pass0, 1);
    @(posedge clk); #1;
    pulse(0, 0);
    @(negedge clk);
    chk("t4_done", done0, 1); chk("t4_passed", pass0, 1); chk("t4_ready", rdy0, 0);
    @(posedge clk); #1;
    pulse(0, 4);
    send(0, 5, 5, 1); send(0, 5, 6, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_err", err0, 0); chk("t5_done", done0, 0); chk("t5_busy", busy0, 0); chk("t5_first", first0, 16'hFFFF);
    @(posedge clk); #1;
    pulse(0, 1);
    send(0, 7, 8, 1);
    @(negedge clk);
    chk("t5_done2", done0, 1); chk("t5_passed", pass0, 1);
    @(posedge clk); #1;
    pulse(1, 3);
    send(1, 1, 1, 1); send(1, 2, 2, 1); send(1, 3, 4, 0);
    @(negedge clk);
    chk("t6_done", done2, 1); chk("t6_err_sat", err2, 3); chk("t6_first", first2, 0); chk("t6_passed", pass2, 0);
    @(posedge clk); #1;
    pulse(1, 3);
    send(1, 1, 1, 0); send(1, 2, 3, 1); send(1, 0, 0, 0);
    @(negedge clk);
    chk("t6r_done", done2, 1); chk("t6r_err", err2, 0); chk("t6r_first", first2, 3); chk("t6r_passed", pass2, 1);
    @(posedge clk);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neq_vector_checker.md
Name: neq_vector_checker

Overview:
- Sequential self-checking consumer for inequality-comparison test vectors.
- Accepts a stream of (a, b, expected_neq) triples over a valid/ready handshake and evaluates a != b for each.
- Counts vectors whose computed result disagrees with the expected result, then issues a PASSED/FAILED verdict once a programmed number of vectors has been consumed.
- Sits downstream of the stimulus generators in the comparison-operator regression benches; replaces ad-hoc error-flag checking.

Parameters:
- WIDTH, 32, operand width of a and b (integer-sized by default).
- COUNT_W, 16, width of the vector counter, error counter and index outputs.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a check run (honoured in IDLE or DONE only).
- num_vec  input  COUNT_W  number of vectors in the run; sampled on accepted start.
- in_valid  input  1  vector present.
- in_ready  output  1  checker accepts vector this cycle.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- in_exp_neq  input  1  expected value of (a != b).
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start or reset.
- passed  output  1  valid when done: 1 if err_count == 0.
- err_count  output  COUNT_W  mismatching vectors so far; saturating.
- first_err_idx  output  COUNT_W  0-based index of the first mismatching vector; all-ones if none.
- cap_a  output  WIDTH  a of first mismatch (feature-dependent).
- cap_b  output  WIDTH  b of first mismatch (feature-dependent).

Behaviour:
- Reset: synchronous, active-high. Takes effect at the next rising clk edge with reset=1, in any state including mid-run.
  - State returns to IDLE.
  - busy=0, done=0, passed=0, in_ready=0, err_count=0.
  - first_err_idx=all-ones; cap_a=0, cap_b=0.
  - All internal counters clear; no partial result is retained.
- States:
  - IDLE: in_ready=0. start=1 with num_vec>0 -> RUN, next cycle. start=1 with num_vec==0 -> DONE with passed=1.
  - RUN: busy=1, in_ready=1. A vector is accepted on a clk edge where in_valid && in_ready.
  - DONE: busy=0, done=1, in_ready=0. start=1 -> clear results and re-enter RUN, or DONE again if num_vec==0.
- Entering RUN clears err_count, the vector index, first_err_idx (to all-ones) and the capture registers.
- Per accepted vector:
  - Compute neq = (in_a != in_b), full WIDTH bits, unsigned bitwise compare.
  - Mismatch when neq != in_exp_neq.
  - On mismatch, err_count increments, saturating at 2^COUNT_W-1.
  - If this is the first mismatch of the run, first_err_idx <= current index.
  - The index then increments.
- Completion: the edge accepting vector number num_vec-1 moves the FSM to DONE.
  - done=1 in the following cycle, i.e. latency 1 cycle after the final handshake.
  - passed is registered on that same edge, so it includes the final vector.
- in_valid=0 in RUN: no state change; the run stalls indefinitely.
- start while in RUN: ignored.
- Inputs outside RUN are ignored; in_ready=0 outside RUN.
- Outputs are all registered; no combinational path from in_* to outputs other than in_ready, which depends on state only.

Optional Feature:
- Macro: NEQ_CHECK_CAPTURE_EN.
- Defined: on the first mismatch of a run, cap_a/cap_b latch in_a/in_b and hold until the next run start or reset.
- Undefined: cap_a/cap_b are tied to 0 and no capture registers exist. All other behaviour is identical.

Test Plan:
- num_vec=5; vectors (0,0,0), (1,0,1), (1,1,0), (1002,1001,1), (1001,1001,0), one per cycle -> done one cycle after 5th handshake; passed=1, err_count=0, first_err_idx=16'hFFFF.
- Same vectors, but the 3rd has exp_neq=1 and the 5th has exp_neq=1 -> passed=0, err_count=2, first_err_idx=2. With NEQ_CHECK_CAPTURE_EN: cap_a=1, cap_b=1.
- num_vec=3; in_valid deasserted for 4 cycles between vectors 1 and 2 -> busy held, done only after 3rd handshake; start pulse during RUN has no effect.
- start with num_vec=0 -> done=1 and passed=1 next cycle; in_ready never asserted.
- reset asserted after 2 of 4 vectors accepted, one with a mismatch -> next cycle IDLE, err_count=0, done=0; new start with num_vec=1 and a correct vector -> passed=1.
- COUNT_W=2, num_vec=3 all mismatching, then rerun via start from DONE with num_vec=3 and 3 correct vectors -> first run err_count=3 (saturation boundary reached, no wrap); rerun err_count=0, passed=1.
